pp_accum_seq: RTL
=================

# pp_accum_seq

Sequential, parametrised carry-save accumulator for the modular-squaring datapath. It takes a stream of column-aligned carry-save partial-product beats and folds each beat into a registered per-column redundant accumulator, one beat per cycle, using a 6:2 compressor per column. It re-aligns each input digit's high bits into the next column. On the last beat it presents the accumulated carry/sum columns to the reduction stage through a valid/ready handshake.

## Interface
- NUM_COLS, 130: number of output columns.
- IN_W, 25: width of each input carry/sum digit.
- DIGIT_W, 16: column radix bits; input bits [IN_W-1:DIGIT_W] move to column m+1.
- ACC_W, 20: width of each accumulated carry/sum column.
- CNT_W, 8: beat-counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous active-low.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_first  in  1  beat starts a new accumulation; accumulator treated as zero.
- in_last  in  1  beat ends the accumulation.
- in_c, in_s  in  [NUM_COLS][IN_W]  carry-save input digits.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_c, out_s  out  [NUM_COLS][ACC_W]  accumulated carry/sum columns.
- beat_cnt  out  CNT_W  beats folded into the current or held result.
- overflow  out  1  sticky; set when dropped bits are nonzero.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- Per accepted beat, column m combines six operands: acc_c[m], acc_s[m], in_s[m][DIGIT_W-1:0], in_c[m][DIGIT_W-1:0], in_s[m-1][IN_W-1:DIGIT_W] and in_c[m-1][IN_W-1:DIGIT_W].
  - All six are zero-extended to ACC_W.
  - Column 0 has no high-part operands.
  - They reduce to a new (c, s) pair.
  - acc_c and acc_s are zero when in_first is set.
- Invariant: Σ_m (out_c[m]+out_s[m])·2^(DIGIT_W·m) ≡ Σ over beats of Σ_m (in_c[m]+in_s[m])·2^(DIGIT_W·m), modulo 2^(DIGIT_W·NUM_COLS+ACC_W-DIGIT_W).
- Overflow sources:
  - Nonzero high bits of column NUM_COLS-1 are discarded and set overflow.
  - Any compressor bit at position ≥ ACC_W is discarded and sets overflow.
- IDLE:
  - Beat with in_first && !in_last → ACCUM, beat_cnt=1.
  - Beat with in_first && in_last → HOLD.
  - Beat without in_first is consumed and ignored, and sets proto_err.
- ACCUM:
  - Beat without in_first: fold it and increment beat_cnt. If in_last → HOLD.
  - Beat with in_first: restart (accumulator cleared, beat_cnt=1), set proto_err, stay in ACCUM unless in_last.
- beat_cnt saturates at 2^CNT_W-1; reaching saturation sets proto_err.
- HOLD:
  - out_valid=1, and out_c, out_s and beat_cnt stay stable.
  - in_ready=out_ready.
  - On out_ready without an accepted beat → IDLE.
  - On out_ready with an accepted beat: the beat is processed as if in IDLE, in the same cycle (back-to-back).
- overflow and proto_err clear only on reset.

## Timing
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_c=out_s=0, beat_cnt=0, overflow=0, proto_err=0.
- in_ready=1 in IDLE and ACCUM, and is combinational from out_ready in HOLD. There is no other in→out combinational path.
- Latency: out_valid rises on the edge that accepts the in_last beat, i.e. the result is visible the cycle after that beat.
- Throughput: one beat per cycle. The handoff HOLD→next accumulation adds zero bubbles.
- Reset mid-accumulation discards all state. The first post-reset beat must carry in_first.

## Structure
- Package pp_accum_pkg holds:
  - the default widths (NUM_COLS, IN_W, DIGIT_W, ACC_W);
  - the state enum typedef;
  - a localparam HI_W = IN_W-DIGIT_W;
  - the static requirement ACC_W ≥ DIGIT_W+3.
- Sub-module csa_6to2 (parametrised width ACC_W, outputs c/s plus a dropped-bit flag), instantiated NUM_COLS times in a generate loop.
- Top level contains the operand alignment, FSM, counter, accumulator registers and sticky flags.

## Test plan
All scenarios use NUM_COLS=4.
- Single beat with first and last, in_s[0]=0x10005, all else 0 → next cycle out_valid=1, column sums col0=5 and col1=1, beat_cnt=1.
- Three beats each with in_c[2]=0x0FFFF, out_ready held 0 → in_ready=0 after the last beat, col2+col3·2^16 sum=0x2FFFD, stable until out_ready.
- Back-to-back: a second first/last beat offered in the HOLD cycle with out_ready=1 → accepted, out_valid stays 1, new value appears next cycle.
- Beat without in_first in IDLE → ignored, proto_err=1, out_valid stays 0.
- in_s[3]=0x1FFFFFF → overflow=1 and high bits dropped; overflow remains set across subsequent accumulations.
- rst_n pulled low mid-ACCUM (after 2 beats) → all outputs 0 immediately; a fresh first/last beat then yields only its own value.

Source files
------------

// File: rtl/pp_accum_pkg.sv
// Shared defaults, state encoding and static checks for the carry-save
// partial-product accumulator.
package pp_accum_pkg;

  localparam int NUM_COLS = 130;
  localparam int IN_W     = 25;
  localparam int DIGIT_W  = 16;
  localparam int ACC_W    = 20;
  localparam int CNT_W    = 8;
  localparam int HI_W     = IN_W - DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // A column must absorb its own digit pair plus the neighbour's high bits
  // and the fed-back carry/sum without immediate wrap.
  function automatic bit acc_w_ok(input int acc_w, input int digit_w);
    return acc_w >= digit_w + 3;
  endfunction

endpackage

// File: rtl/csa_6to2.sv
// Six-operand carry-save compressor: four 3:2 stages reduce six W-bit words
// to a carry/sum pair, flagging any carry bit pushed past bit W-1.
module csa_6to2
  import pp_accum_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [5:0][W-1:0] op,
  output logic [W-1:0]      c,
  output logic [W-1:0]      s,
  output logic              drop
);

  logic [W-1:0] s1, m1, s2, m2, s3, m3, m4;
  logic [W-1:0] sh1, sh2, sh3;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    s1  = op[0] ^ op[1] ^ op[2];
    m1  = (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
    s2  = op[3] ^ op[4] ^ op[5];
    m2  = (op[3] & op[4]) | (op[3] & op[5]) | (op[4] & op[5]);
    sh1 = {m1[W-2:0], 1'b0};
    sh2 = {m2[W-2:0], 1'b0};

    s3  = s1 ^ sh1 ^ s2;
    m3  = (s1 & sh1) | (s1 & s2) | (sh1 & s2);
    sh3 = {m3[W-2:0], 1'b0};

    s   = s3 ^ sh3 ^ sh2;
    m4  = (s3 & sh3) | (s3 & sh2) | (sh3 & sh2);
    c   = {m4[W-2:0], 1'b0};

    drop = m1[W-1] | m2[W-1] | m3[W-1] | m4[W-1];
  end

endmodule

// File: rtl/pp_accum_seq.sv
// Sequential carry-save accumulator: folds one column-aligned partial-product
// beat per cycle into per-column redundant registers and hands the result on.
module pp_accum_seq #(
  parameter int NUM_COLS = pp_accum_pkg::NUM_COLS,
  parameter int IN_W     = pp_accum_pkg::IN_W,
  parameter int DIGIT_W  = pp_accum_pkg::DIGIT_W,
  parameter int ACC_W    = pp_accum_pkg::ACC_W,
  parameter int CNT_W    = pp_accum_pkg::CNT_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [NUM_COLS-1:0][IN_W-1:0]    in_c,
  input  logic [NUM_COLS-1:0][IN_W-1:0]    in_s,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_COLS-1:0][ACC_W-1:0]   out_c,
  output logic [NUM_COLS-1:0][ACC_W-1:0]   out_s,
  output logic [CNT_W-1:0]                 beat_cnt,
  output logic                             overflow,
  output logic                             proto_err
);

  import pp_accum_pkg::*;

  localparam int              HW      = IN_W - DIGIT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!acc_w_ok(ACC_W, DIGIT_W)) begin : g_bad_acc_w
    $error("pp_accum_seq: ACC_W must be at least DIGIT_W+3");
  end

  state_e                          state;
  logic [NUM_COLS-1:0][ACC_W-1:0]  acc_c, acc_s;
  logic [NUM_COLS-1:0][ACC_W-1:0]  nxt_c, nxt_s;
  logic [NUM_COLS-1:0]             col_drop;
  logic                            top_drop;
  logic                            accept;
  logic                            fold;

  assign in_ready = (state == ST_HOLD) ? out_ready : 1'b1;
  assign accept   = in_valid && in_ready;
  // Stray beats (no in_first outside ACCUM) are consumed without touching the accumulator.
  assign fold     = accept && (in_first || state == ST_ACCUM);

  assign top_drop = (|in_s[NUM_COLS-1][IN_W-1:DIGIT_W]) | (|in_c[NUM_COLS-1][IN_W-1:DIGIT_W]);

  for (genvar m = 0; m < NUM_COLS; m++) begin : g_col
    logic [5:0][ACC_W-1:0] op;

    assign op[0] = in_first ? '0 : acc_c[m];
    assign op[1] = in_first ? '0 : acc_s[m];
    assign op[2] = ACC_W'(in_s[m][DIGIT_W-1:0]);
    assign op[3] = ACC_W'(in_c[m][DIGIT_W-1:0]);

    if (m == 0) begin : g_lo
      assign op[4] = '0;
      assign op[5] = '0;
    end else begin : g_hi
      logic [HW-1:0] hi_s, hi_c;
      assign hi_s  = in_s[m-1][IN_W-1:DIGIT_W];
      assign hi_c  = in_c[m-1][IN_W-1:DIGIT_W];
      assign op[4] = ACC_W'(hi_s);
      assign op[5] = ACC_W'(hi_c);
    end

    csa_6to2 #(.W(ACC_W)) u_csa (
      .op   (op),
      .c    (nxt_c[m]),
      .s    (nxt_s[m]),
      .drop (col_drop[m])
    );
  end

  assign out_c = acc_c;
  assign out_s = acc_s;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      // NOTE: the accumulator array is reset too, since out_c/out_s must read zero after reset.
      acc_c     <= '0;
      acc_s     <= '0;
    end else begin
      if (fold) begin
        acc_c <= nxt_c;
        acc_s <= nxt_s;
        if ((|col_drop) || top_drop) overflow <= 1'b1;
      end

      case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (in_first) begin
              beat_cnt  <= CNT_W'(1);
              proto_err <= 1'b1;
            end else if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == CNT_MAX - 1'b1) proto_err <= 1'b1;
            end
            if (in_last) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
            end
          end
        end

        default: begin
          // IDLE, or HOLD being drained: a new beat starts back-to-back.
          if (state == ST_IDLE || out_ready) begin
            if (accept && in_first) begin
              beat_cnt  <= CNT_W'(1);
              state     <= in_last ? ST_HOLD : ST_ACCUM;
              out_valid <= in_last;
            end else begin
              if (accept) proto_err <= 1'b1;
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
